com_unit: RTL and testbench

- Framed UART transmitter plus independent UART byte receiver for the on-chip variable monitor.
- On request, sends one frame: start word, variable count, NUMBER_OF_VARIABLES data words, end word. Every word goes MSB byte first.
- Data words are not a bus input. They are fetched byte-by-byte through an external mux: com_unit drives the word index and bit offset, and the parent returns the addressed byte.
- The receiver deserialises inputRx and pulses doneRx once per valid byte.

---
 rtl/monit_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 53 +++++
 rtl/com_unit.sv | 172 +++++++++++++++++
 tb/tb_com_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/monit_pkg.sv
// monit_pkg: shared frame constants and FSM state types for the variable-monitor UART link.
package monit_pkg;
    localparam logic [31:0] START_WORD_DEF      = 32'h2F2F0D0A;
    localparam logic [31:0] END_WORD_DEF        = 32'h5C5C0D0A;
    localparam int          VARIABLE_LENGTH_DEF = 32;
    localparam int          BYTES_PER_WORD      = VARIABLE_LENGTH_DEF / 8;

    typedef enum logic [2:0] {
        TX_IDLE, TX_HEADER, TX_COUNT, TX_DATA, TX_TRAILER, TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    function automatic int bytes_per_word(input int variable_length);
        return variable_length / 8;
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser; a load accepted during the last stop-bit cycle chains bytes with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          busy_q, busy_d;
    logic [9:0]    sh_q, sh_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_end;

    // Ones shift in behind the frame, so sh_q[0] doubles as the idle-high line.
    always_comb begin
        bit_end   = busy_q && (cnt_q == CW'(CLKS_PER_BIT - 1));
        byte_done = bit_end && (bit_q == 4'd9);
        busy_d    = byte_done ? 1'b0 : busy_q;
        sh_d      = bit_end ? {1'b1, sh_q[9:1]} : sh_q;
        bit_d     = bit_end ? bit_q + 4'd1 : bit_q;
        cnt_d     = (busy_q && !bit_end) ? cnt_q + 1'b1 : '0;
        if (load && (!busy_q || byte_done)) begin
            busy_d = 1'b1;
            sh_d   = {1'b1, data, 1'b0};
            bit_d  = 4'd0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            sh_q   <= '1;
            bit_q  <= 4'd0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tx   = sh_q[0];
    assign busy = busy_q;
endmodule

// File: rtl/com_unit.sv
// com_unit: framed UART transmitter for the variable monitor plus an independent UART byte receiver.
// TX position registers always point at the next byte to load, so the data mux indices settle a whole byte early.
module com_unit
    import monit_pkg::*;
#(
    parameter int                         VARIABLE_LENGTH     = 32,
    parameter int                         NUMBER_OF_VARIABLES = 10,
    parameter int                         CLKS_PER_BIT        = 868,
    parameter logic [VARIABLE_LENGTH-1:0] START_WORD          = VARIABLE_LENGTH'(START_WORD_DEF),
    parameter logic [VARIABLE_LENGTH-1:0] END_WORD            = VARIABLE_LENGTH'(END_WORD_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       startComm,
    input  logic [VARIABLE_LENGTH-1:0] numberOfVariables,
    input  logic [7:0]                 senderConnector,
    output logic [7:0]                 variableIndex,
    output logic [7:0]                 singleVariablePartIndex,
    output logic                       outputTx,
    output logic                       doneTx,
    input  logic                       inputRx,
    output logic [7:0]                 outputRx,
    output logic                       doneRx
);
    localparam int BPW = bytes_per_word(VARIABLE_LENGTH);
    localparam int CW  = $clog2(CLKS_PER_BIT);

    tx_state_t                state_q, state_d, ld_state;
    logic [7:0]               part_q, part_d, var_q, var_d, ld_part, tx_byte;
    logic                     fin_q, fin_d, load, tx_busy, tx_byte_done;
    logic [VARIABLE_LENGTH-1:0] count_q, count_d, ld_word;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (tx_byte),
        .tx        (outputTx),
        .busy      (tx_busy),
        .byte_done (tx_byte_done)
    );

    always_comb begin
        state_d  = state_q;
        part_d   = part_q;
        var_d    = var_q;
        fin_d    = fin_q;
        count_d  = count_q;
        ld_state = (state_q == TX_IDLE) ? TX_HEADER : state_q;
        ld_part  = (state_q == TX_IDLE) ? 8'(BPW - 1) : part_q;
        ld_word  = (ld_state == TX_HEADER) ? START_WORD : (ld_state == TX_COUNT) ? count_q : END_WORD;
        tx_byte  = (ld_state == TX_DATA) ? senderConnector : 8'(ld_word >> {ld_part, 3'b000});
        load     = (state_q == TX_IDLE) ? (startComm && !tx_busy)
                                        : (state_q != TX_DONE) && tx_byte_done && !fin_q;
        if (state_q == TX_IDLE && load)
            count_d = numberOfVariables;
        if (load) begin
            if (ld_part != 8'd0) begin
                state_d = ld_state;
                part_d  = ld_part - 8'd1;
            end else begin
                part_d = 8'(BPW - 1);
                case (ld_state)
                    TX_HEADER: state_d = TX_COUNT;
                    TX_COUNT:  state_d = TX_DATA;
                    TX_DATA: begin
                        state_d = (var_q == 8'(NUMBER_OF_VARIABLES - 1)) ? TX_TRAILER : TX_DATA;
                        var_d   = (var_q == 8'(NUMBER_OF_VARIABLES - 1)) ? 8'd0 : var_q + 8'd1;
                    end
                    default: begin
                        state_d = TX_TRAILER;
                        fin_d   = 1'b1;
                    end
                endcase
            end
        end
        // Last trailer byte already loaded: wait for its stop bit to finish.
        if (state_q == TX_TRAILER && fin_q && tx_byte_done) begin
            state_d = TX_DONE;
            fin_d   = 1'b0;
        end
        if (state_q == TX_DONE) begin
            state_d = TX_IDLE;
            part_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            part_q  <= 8'd0;
            var_q   <= 8'd0;
            fin_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            var_q   <= var_d;
            fin_q   <= fin_d;
            count_q <= count_d;
        end
    end

    assign doneTx                  = (state_q == TX_DONE);
    assign variableIndex           = (state_q == TX_DATA) ? var_q : 8'd0;
    assign singleVariablePartIndex = (state_q == TX_DATA) ? {part_q[4:0], 3'b000} : 8'd0;

    rx_state_t     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q, rx_done_q, rx_done_d, rx_mid, rx_full;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_out_q, rx_out_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_out_d   = rx_out_q;
        rx_done_d  = 1'b0;
        rx_mid     = (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
        rx_full    = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_START;
            end
            RX_START: if (rx_mid) begin
                rx_cnt_d   = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_full) begin
                rx_cnt_d   = '0;
                rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            default: if (rx_full) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                rx_out_d   = rx_s2_q ? rx_sh_q : rx_out_q;
                rx_done_d  = rx_s2_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_out_q   <= 8'd0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_s1_q    <= inputRx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_out_q   <= rx_out_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign outputRx = rx_out_q;
    assign doneRx   = rx_done_q;
endmodule

// File: tb/tb_com_unit.sv
// tb_com_unit: directed checks of com_unit framing, data fetch, loopback RX, glitch/stop rejection and reset abort.
module tb_com_unit;
    localparam int CPB  = 4;
    localparam int BITS = 10 * CPB;
    localparam int NB   = 20;

    logic        clk = 1'b0, rst = 1'b0, startComm = 1'b0, rx_drv = 1'b1, loop = 1'b0;
    logic [31:0] numberOfVariables = 32'h2;
    logic [7:0]  senderConnector, variableIndex, singleVariablePartIndex, outputRx;
    logic        outputTx, doneTx, doneRx, inputRx;

    logic [31:0] words     [0:1]    = '{32'h40303030, 32'h12345678};
    logic [7:0]  exp_bytes [0:NB-1] = '{8'h2F, 8'h2F, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h02,
                                        8'h40, 8'h30, 8'h30, 8'h30, 8'h12, 8'h34, 8'h56, 8'h78,
                                        8'h5C, 8'h5C, 8'h0D, 8'h0A};

    int errors = 0, checks = 0, rx_pulses = 0;
    logic       line_a [0:2047];
    logic       dtx_a  [0:2047];
    logic [7:0] vi_a   [0:2047];
    logic [7:0] pi_a   [0:2047];
    logic [7:0] rxq    [$];

    com_unit #(
        .VARIABLE_LENGTH(32), .NUMBER_OF_VARIABLES(2), .CLKS_PER_BIT(CPB),
        .START_WORD(32'h2F2F0D0A), .END_WORD(32'h5C5C0D0A)
    ) dut (
        .clk(clk), .rst(rst), .startComm(startComm), .numberOfVariables(numberOfVariables),
        .senderConnector(senderConnector), .variableIndex(variableIndex),
        .singleVariablePartIndex(singleVariablePartIndex), .outputTx(outputTx), .doneTx(doneTx),
        .inputRx(inputRx), .outputRx(outputRx), .doneRx(doneRx)
    );

    always #5 clk = ~clk;
    assign inputRx = loop ? outputTx : rx_drv;
    always_comb senderConnector = 8'(words[variableIndex[0]] >> singleVariablePartIndex);
    always @(negedge clk) if (doneRx) rx_pulses <= rx_pulses + 1;

    // Sample k is taken at the negedge after the k-th posedge; posedge 1 is the one that sees startComm.
    task automatic capture(input int n, input int drop_at);
        rxq.delete();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            line_a[k] = outputTx;
            dtx_a[k]  = doneTx;
            vi_a[k]   = variableIndex;
            pi_a[k]   = singleVariablePartIndex;
            if (doneRx) rxq.push_back(outputRx);
            if (k == drop_at) startComm = 1'b0;
        end
    endtask

    function automatic logic [9:0] frame_bits(input int base, input int j);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = line_a[base + BITS * j + CPB * b + CPB / 2];
        return r;
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_drv = f[b];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b0;
        startComm = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (outputTx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", outputTx); end
        checks++; if (doneTx !== 1'b0 || doneRx !== 1'b0) begin errors++; $display("FAIL reset_done: got tx=%b rx=%b expected 0 0", doneTx, doneRx); end
        checks++; if (outputRx !== 8'h00) begin errors++; $display("FAIL reset_rxbyte: got %h expected 00", outputRx); end
        checks++; if (variableIndex !== 8'd0 || singleVariablePartIndex !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", variableIndex, singleVariablePartIndex); end
        rst = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (outputTx !== 1'b1 || doneTx !== 1'b0 || variableIndex !== 8'd0 || singleVariablePartIndex !== 8'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_50: got %0d non-idle cycles expected 0", bad); end
    endtask

    task automatic test_frame;
        int n, at, hi;
        @(negedge clk);
        startComm = 1'b1;
        capture(BITS * NB + 30, 1);
        checks++; if (line_a[1] !== 1'b0) begin errors++; $display("FAIL first_start: got %b expected 0", line_a[1]); end
        for (int j = 0; j < NB; j++) begin
            checks++;
            if (frame_bits(1, j) !== {1'b1, exp_bytes[j], 1'b0}) begin
                errors++; $display("FAIL frame_byte%0d: got %b expected %b", j, frame_bits(1, j), {1'b1, exp_bytes[j], 1'b0});
            end
        end
        n = 0; at = 0;
        for (int k = 1; k <= BITS * NB + 30; k++) if (dtx_a[k]) begin n++; at = k; end
        checks++; if (n !== 1 || at !== BITS * NB + 1) begin errors++; $display("FAIL done_tx: got %0d pulses at %0d expected 1 at %0d", n, at, BITS * NB + 1); end
        hi = 0;
        for (int k = BITS * NB + 1; k <= BITS * NB + 30; k++) if (line_a[k] !== 1'b1) hi++;
        checks++; if (hi !== 0) begin errors++; $display("FAIL idle_after: got %0d low cycles expected 0", hi); end
        checks++; if (vi_a[100] !== 8'd0 || pi_a[100] !== 8'd0) begin errors++; $display("FAIL header_idx: got %0d/%0d expected 0/0", vi_a[100], pi_a[100]); end
    endtask

    task automatic test_loopback;
        loop = 1'b1;
        @(negedge clk);
        startComm = 1'b1;
        capture(BITS * NB + 30, 1);
        loop = 1'b0;
        checks++; if (rxq.size() !== NB) begin errors++; $display("FAIL loop_count: got %0d expected %0d", rxq.size(), NB); end
        for (int j = 0; j < NB && j < rxq.size(); j++) begin
            checks++;
            if (rxq[j] !== exp_bytes[j]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", j, rxq[j], exp_bytes[j]); end
        end
    endtask

    task automatic test_rx_robust;
        int p0;
        p0 = rx_pulses;
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (rx_pulses !== p0) begin errors++; $display("FAIL rx_glitch: got %0d pulses expected 0", rx_pulses - p0); end
        send_rx(8'h6C, 1'b0);
        repeat (12) @(negedge clk);
        checks++; if (rx_pulses !== p0) begin errors++; $display("FAIL rx_badstop: got %0d pulses expected 0", rx_pulses - p0); end
        checks++; if (outputRx !== 8'h0A) begin errors++; $display("FAIL rx_hold: got %h expected 0a", outputRx); end
        send_rx(8'h23, 1'b1);
        repeat (12) @(negedge clk);
        checks++; if (rx_pulses !== p0 + 1) begin errors++; $display("FAIL rx_valid_pulse: got %0d pulses expected 1", rx_pulses - p0); end
        checks++; if (outputRx !== 8'h23) begin errors++; $display("FAIL rx_valid_byte: got %h expected 23", outputRx); end
    endtask

    task automatic test_back_to_back;
        int n, a0, a1, hi;
        @(negedge clk);
        startComm = 1'b1;
        capture(2 * (BITS * NB + 2) + 8, 2 * (BITS * NB + 2));
        n = 0; a0 = 0; a1 = 0;
        for (int k = 1; k <= 2 * (BITS * NB + 2) + 8; k++) if (dtx_a[k]) begin n++; if (n == 1) a0 = k; else a1 = k; end
        checks++; if (n !== 2 || a0 !== 801 || a1 !== 1603) begin errors++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at 801,1603", n, a0, a1); end
        checks++; if (line_a[802] !== 1'b1 || line_a[803] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b%b expected 10", line_a[802], line_a[803]); end
        checks++; if (frame_bits(803, 0) !== {1'b1, 8'h2F, 1'b0}) begin errors++; $display("FAIL b2b_first: got %b expected %b", frame_bits(803, 0), {1'b1, 8'h2F, 1'b0}); end
        hi = 0;
        for (int k = 1605; k <= 2 * (BITS * NB + 2) + 8; k++) if (line_a[k] !== 1'b1) hi++;
        checks++; if (hi !== 0) begin errors++; $display("FAIL b2b_stop: got %0d low cycles expected 0", hi); end
    endtask

    task automatic test_mid_reset;
        int n, at;
        @(negedge clk);
        startComm = 1'b1;
        capture(500, 1);
        n = 0;
        for (int k = 1; k <= 500; k++) if (dtx_a[k]) n++;
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_early_done: got %0d expected 0", n); end
        checks++; if (vi_a[400] !== 8'd0 || pi_a[400] !== 8'd8) begin errors++; $display("FAIL mid_idx400: got %0d/%0d expected 0/8", vi_a[400], pi_a[400]); end
        checks++; if (vi_a[500] !== 8'd1 || pi_a[500] !== 8'd16) begin errors++; $display("FAIL mid_idx500: got %0d/%0d expected 1/16", vi_a[500], pi_a[500]); end
        checks++; if (line_a[500] !== 1'b0) begin errors++; $display("FAIL mid_line: got %b expected 0", line_a[500]); end
        rst = 1'b0;
        #1;
        checks++; if (outputTx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", outputTx); end
        checks++; if (variableIndex !== 8'd0 || singleVariablePartIndex !== 8'd0) begin errors++; $display("FAIL abort_idx: got %0d/%0d expected 0/0", variableIndex, singleVariablePartIndex); end
        repeat (3) @(negedge clk);
        checks++; if (outputTx !== 1'b1 || doneTx !== 1'b0) begin errors++; $display("FAIL abort_hold: got tx=%b done=%b expected 1 0", outputTx, doneTx); end
        rst = 1'b1;
        startComm = 1'b1;
        capture(BITS * NB + 30, 1);
        checks++; if (line_a[1] !== 1'b0) begin errors++; $display("FAIL restart_start: got %b expected 0", line_a[1]); end
        for (int j = 0; j < NB; j++) begin
            checks++;
            if (frame_bits(1, j) !== {1'b1, exp_bytes[j], 1'b0}) begin
                errors++; $display("FAIL restart_byte%0d: got %b expected %b", j, frame_bits(1, j), {1'b1, exp_bytes[j], 1'b0});
            end
        end
        n = 0; at = 0;
        for (int k = 1; k <= BITS * NB + 30; k++) if (dtx_a[k]) begin n++; at = k; end
        checks++; if (n !== 1 || at !== BITS * NB + 1) begin errors++; $display("FAIL restart_done: got %0d pulses at %0d expected 1 at %0d", n, at, BITS * NB + 1); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_loopback();
        test_rx_robust();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
